voice_buf_sched: RTL and testbench

//  Scheduler in front of sdramfifo for the voice path. Streams capture samples into the

---
 rtl/voice_pkg.sv | 20 ++
 rtl/voice_pb_fifo.sv | 84 ++++++++
 rtl/voice_buf_sched.sv | 151 +++++++++++++++
 tb/tb_voice_buf_sched.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_pkg.sv
// Shared definitions for the voice playback scheduler and its playback FIFO.
package voice_pkg;

    // Words per sdramfifo burst; a read wave is WAVE_SIZE bursts.
    localparam int SDRAM_BURST_SIZE = 8;

    // Sample width shared with sdramfifo.
    localparam int DATA_WIDTH = 16;

    // Cycles the read strobe stays low after a wave so trailing words can land.
    localparam int GAP_CYCLES = 4;

    // Scheduler states, one-hot.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_READ = 3'b010,
        ST_GAP  = 3'b100
    } state_t;

endpackage

// File: rtl/voice_pb_fifo.sv
// Single-clock playback FIFO with occupancy output and registered read data.
// A read on an empty FIFO returns silence (zero) without a valid pulse.
module voice_pb_fifo
    import voice_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  full;
    logic                  do_wr;
    logic                  do_rd;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    // Writes into a full FIFO are discarded; a flush also discards the word.
    assign do_wr = wr & ~full & ~flush;
    assign do_rd = rd & ~empty;

    // Storage array; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; flush empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Registered read port: data plus a one-cycle valid pulse, silence on empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            if (do_rd) begin
                rd_data <= mem[rd_ptr];
            end else if (rd) begin
                rd_data <= '0;
            end
        end
    end

endmodule

// File: rtl/voice_buf_sched.sv
// Voice path scheduler in front of sdramfifo: gates capture writes into the
// sdramfifo cache and schedules whole-wave reads to refill the playback FIFO.
//
// Handshakes: there is no back-pressure on any interface. o_fifo_wr is a
// per-cycle write strobe qualified by !i_fifo_full; o_fifo_rd is a level
// request held for a whole wave; every cycle with i_fifo_rd_ef carries one
// word that is accepted unconditionally; i_pb_req takes one sample per
// cycle and is answered one cycle later by o_pb_valid (or silence on empty).
module voice_buf_sched
    import voice_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int WAVE_SIZE     = 16,
    parameter int PB_ADDR_WIDTH = 8,
    parameter int LOW_WATER     = 64,
    parameter int RD_TIMEOUT    = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_enable,
    input  logic                     i_cap_valid,
    input  logic [DATA_WIDTH-1:0]    i_cap_data,
    output logic                     o_cap_drop,
    input  logic                     i_pb_req,
    output logic [DATA_WIDTH-1:0]    o_pb_data,
    output logic                     o_pb_valid,
    output logic                     o_underrun,
    output logic [PB_ADDR_WIDTH:0]   o_pb_level,
    output logic                     o_fifo_wr,
    output logic [DATA_WIDTH-1:0]    o_fifo_wr_data,
    input  logic                     i_fifo_full,
    output logic                     o_fifo_rd,
    input  logic [DATA_WIDTH-1:0]    i_fifo_rd_data,
    input  logic                     i_fifo_rd_ef,
    input  logic                     i_fifo_rd_done,
    output state_t                   o_dbg_state
);

    localparam int WAVE_WORDS = WAVE_SIZE * SDRAM_BURST_SIZE;
    localparam int PB_DEPTH   = 1 << PB_ADDR_WIDTH;
    localparam int LW         = PB_ADDR_WIDTH + 1;
    localparam int TO_W       = $clog2(RD_TIMEOUT + 1);

    state_t           state;
    state_t           state_nx;
    logic [1:0]       gap_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [LW-1:0]    pb_free;
    logic             pb_empty;
    logic             start_ok;
    logic             flush;

    assign o_dbg_state = state;

    // Capture path: straight through, gated by enable and cache space.
    assign o_fifo_wr      = i_enable & i_cap_valid & ~i_fifo_full;
    assign o_fifo_wr_data = i_cap_data;

    // A wave is only requested when it is guaranteed to fit.
    assign pb_free  = LW'(PB_DEPTH) - o_pb_level;
    assign start_ok = i_enable && (o_pb_level < LW'(LOW_WATER)) && (pb_free >= LW'(WAVE_WORDS));

    // Disabled and idle: drop whatever playback data is left.
    assign flush = (state == ST_IDLE) && !i_enable;

    // Next-state logic for the refill scheduler.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nx = ST_READ;
                end
            end
            ST_READ: begin
                if (i_fifo_rd_done || (to_cnt == TO_W'(RD_TIMEOUT)) || !i_enable) begin
                    state_nx = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == 2'(GAP_CYCLES - 1)) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register; the read request is registered from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            o_fifo_rd <= 1'b0;
        end else begin
            state     <= state_nx;
            o_fifo_rd <= (state_nx == ST_READ);
        end
    end

    // Gap length counter; wraps back to zero as the gap ends.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gap_cnt <= '0;
        end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt + 1'b1;
        end else begin
            gap_cnt <= '0;
        end
    end

    // Idle-cycle counter while reading; any arriving word restarts it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            to_cnt <= '0;
        end else if (state != ST_READ || i_fifo_rd_ef) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_W'(RD_TIMEOUT)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Drop pulse and sticky underrun flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cap_drop <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            o_cap_drop <= i_enable & i_cap_valid & i_fifo_full;
            if (i_pb_req && pb_empty) begin
                o_underrun <= 1'b1;
            end
        end
    end

    voice_pb_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (PB_ADDR_WIDTH)
    ) u_pb_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .flush    (flush),
        .wr       (i_fifo_rd_ef),
        .wr_data  (i_fifo_rd_data),
        .rd       (i_pb_req),
        .rd_data  (o_pb_data),
        .rd_valid (o_pb_valid),
        .level    (o_pb_level),
        .empty    (pb_empty)
    );

endmodule

// File: tb/tb_voice_buf_sched.sv
// Bench for voice_buf_sched: a queue-based model of the playback FIFO plus
// scenario tasks for refill scheduling, capture gating, timeout and disable.
module tb_voice_buf_sched;
    import voice_pkg::*;

    localparam int DW = 16;
    localparam int AW = 8;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_enable = 1'b0;
    logic          i_cap_valid = 1'b0;
    logic [DW-1:0] i_cap_data = '0;
    logic          o_cap_drop;
    logic          i_pb_req = 1'b0;
    logic [DW-1:0] o_pb_data;
    logic          o_pb_valid;
    logic          o_underrun;
    logic [AW:0]   o_pb_level;
    logic          o_fifo_wr;
    logic [DW-1:0] o_fifo_wr_data;
    logic          i_fifo_full = 1'b0;
    logic          o_fifo_rd;
    logic [DW-1:0] i_fifo_rd_data = '0;
    logic          i_fifo_rd_ef = 1'b0;
    logic          i_fifo_rd_done = 1'b0;
    state_t        o_dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    voice_buf_sched dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (i_enable),
        .i_cap_valid    (i_cap_valid),
        .i_cap_data     (i_cap_data),
        .o_cap_drop     (o_cap_drop),
        .i_pb_req       (i_pb_req),
        .o_pb_data      (o_pb_data),
        .o_pb_valid     (o_pb_valid),
        .o_underrun     (o_underrun),
        .o_pb_level     (o_pb_level),
        .o_fifo_wr      (o_fifo_wr),
        .o_fifo_wr_data (o_fifo_wr_data),
        .i_fifo_full    (i_fifo_full),
        .o_fifo_rd      (o_fifo_rd),
        .i_fifo_rd_data (i_fifo_rd_data),
        .i_fifo_rd_ef   (i_fifo_rd_ef),
        .i_fifo_rd_done (i_fifo_rd_done),
        .o_dbg_state    (o_dbg_state)
    );

    // ---------------- reference model (expected queue) ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_data = '0;
    logic          exp_valid = 1'b0;
    logic          exp_underrun = 1'b0;
    bit            model_was_full;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_data     = '0;
            exp_valid    = 1'b0;
            exp_underrun = 1'b0;
        end else begin
            model_was_full = (exp_q.size() == 256);
            exp_valid = 1'b0;
            if (i_pb_req) begin
                if (exp_q.size() > 0) begin
                    exp_data  = exp_q.pop_front();
                    exp_valid = 1'b1;
                end else begin
                    exp_data     = '0;
                    exp_underrun = 1'b1;
                end
            end
            if (i_fifo_rd_ef && !model_was_full) begin
                exp_q.push_back(i_fifo_rd_data);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_cap_valid    = 1'b0;
        i_cap_data     = '0;
        i_pb_req       = 1'b0;
        i_fifo_full    = 1'b0;
        i_fifo_rd_data = '0;
        i_fifo_rd_ef   = 1'b0;
        i_fifo_rd_done = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        i_enable = 1'b0;
        idle_inputs();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_rd_high(input string name, input int budget);
        int n;
        n = 0;
        while (o_fifo_rd !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (o_fifo_rd !== 1'b1) begin
            errors++;
            $display("FAIL %s: o_fifo_rd=%b after %0d cycles, want 1", name, o_fifo_rd, n);
        end
    endtask

    task automatic send_words(input int count);
        for (int i = 0; i < count; i++) begin
            i_fifo_rd_ef   = 1'b1;
            i_fifo_rd_data = 16'($urandom_range(1, 65535));
            tick();
        end
        i_fifo_rd_ef = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n    = 1'b0;
        i_enable = 1'b0;
        idle_inputs();
        repeat (2) tick();
        checks++; if (o_fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_fifo_rd: got %b want 0", o_fifo_rd); end
        checks++; if (o_fifo_wr !== 1'b0) begin errors++; $display("FAIL reset_fifo_wr: got %b want 0", o_fifo_wr); end
        checks++; if (o_cap_drop !== 1'b0) begin errors++; $display("FAIL reset_cap_drop: got %b want 0", o_cap_drop); end
        checks++; if (o_pb_valid !== 1'b0) begin errors++; $display("FAIL reset_pb_valid: got %b want 0", o_pb_valid); end
        checks++; if (o_pb_data !== 16'h0) begin errors++; $display("FAIL reset_pb_data: got %h want 0", o_pb_data); end
        checks++; if (o_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", o_underrun); end
        checks++; if (o_pb_level !== 9'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", o_pb_level); end
        checks++; if (o_dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %b want %b", o_dbg_state, ST_IDLE); end
        rst_n = 1'b1;
        repeat (2) tick();
        checks++; if (o_fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_disabled_rd: got %b want 0", o_fifo_rd); end
    endtask

    task automatic test_refill();
        int sent;
        int guard;
        int gap_seen;
        i_enable = 1'b1;
        wait_rd_high("refill_start", 2);
        sent  = 0;
        guard = 0;
        while (sent < 128 && guard < 1000) begin
            guard++;
            if ($urandom_range(0, 3) != 0) begin
                i_fifo_rd_ef   = 1'b1;
                i_fifo_rd_data = 16'($urandom_range(1, 65535));
                sent++;
            end else begin
                i_fifo_rd_ef = 1'b0;
            end
            tick();
            checks++;
            if (o_fifo_rd !== 1'b1) begin errors++; $display("FAIL refill_rd_held: got %b want 1 at word %0d", o_fifo_rd, sent); end
        end
        i_fifo_rd_ef   = 1'b0;
        i_fifo_rd_done = 1'b1;
        tick();
        i_fifo_rd_done = 1'b0;
        checks++; if (o_pb_level !== 9'd128) begin errors++; $display("FAIL refill_level: got %0d want 128", o_pb_level); end
        checks++; if (o_fifo_rd !== 1'b0) begin errors++; $display("FAIL refill_rd_drop: got %b want 0", o_fifo_rd); end
        gap_seen = (o_dbg_state == ST_GAP) ? 1 : 0;
        for (int i = 0; i < 10 && o_dbg_state == ST_GAP; i++) begin
            tick();
            if (o_dbg_state == ST_GAP) gap_seen++;
            checks++;
            if (o_fifo_rd !== 1'b0) begin errors++; $display("FAIL refill_gap_rd: got %b want 0", o_fifo_rd); end
        end
        checks++; if (gap_seen != 4) begin errors++; $display("FAIL refill_gap_len: got %0d cycles want 4", gap_seen); end
        checks++; if (o_dbg_state !== ST_IDLE) begin errors++; $display("FAIL refill_idle: got %b want %b", o_dbg_state, ST_IDLE); end
    endtask

    task automatic test_cap_drop();
        bit fullpat [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int drops;
        drops = 0;
        for (int i = 0; i < 6; i++) begin
            i_cap_valid = 1'b1;
            i_cap_data  = 16'($urandom);
            i_fifo_full = fullpat[i];
            #1;
            checks++;
            if (o_fifo_wr !== !fullpat[i]) begin errors++; $display("FAIL cap_wr[%0d]: got %b want %b", i, o_fifo_wr, !fullpat[i]); end
            checks++;
            if (o_fifo_wr_data !== i_cap_data) begin errors++; $display("FAIL cap_wr_data[%0d]: got %h want %h", i, o_fifo_wr_data, i_cap_data); end
            tick();
            checks++;
            if (o_cap_drop !== fullpat[i]) begin errors++; $display("FAIL cap_drop[%0d]: got %b want %b", i, o_cap_drop, fullpat[i]); end
            if (o_cap_drop === 1'b1) drops++;
        end
        idle_inputs();
        tick();
        checks++; if (drops != 3) begin errors++; $display("FAIL cap_drop_count: got %0d want 3", drops); end
    endtask

    task automatic test_threshold();
        int guard;
        for (int i = 0; i < 72; i++) begin
            i_fifo_rd_ef   = 1'b1;
            i_fifo_rd_data = 16'($urandom_range(1, 65535));
            tick();
            checks++;
            if (o_fifo_rd !== 1'b0) begin errors++; $display("FAIL thr_fill_rd: got %b want 0", o_fifo_rd); end
        end
        i_fifo_rd_ef = 1'b0;
        checks++; if (o_pb_level !== 9'd200) begin errors++; $display("FAIL thr_level200: got %0d want 200", o_pb_level); end
        guard = 0;
        while (exp_q.size() > 64 && guard < 300) begin
            guard++;
            i_pb_req = 1'b1;
            tick();
            checks++;
            if (o_pb_valid !== 1'b1 || o_pb_data !== exp_data) begin
                errors++; $display("FAIL thr_pop: got valid=%b data=%h want valid=1 data=%h", o_pb_valid, o_pb_data, exp_data);
            end
            checks++;
            if (o_fifo_rd !== 1'b0) begin errors++; $display("FAIL thr_no_req: got %b want 0 at level %0d", o_fifo_rd, o_pb_level); end
        end
        i_pb_req = 1'b0;
        tick();
        checks++; if (o_pb_level !== 9'd64) begin errors++; $display("FAIL thr_level64: got %0d want 64", o_pb_level); end
        checks++; if (o_fifo_rd !== 1'b0) begin errors++; $display("FAIL thr_at_water: got %b want 0", o_fifo_rd); end
        i_pb_req = 1'b1;
        tick();
        i_pb_req = 1'b0;
        checks++;
        if (o_pb_valid !== 1'b1 || o_pb_data !== exp_data) begin
            errors++; $display("FAIL thr_last_pop: got valid=%b data=%h want valid=1 data=%h", o_pb_valid, o_pb_data, exp_data);
        end
        wait_rd_high("thr_below_water", 3);
    endtask

    task automatic test_timeout();
        int n;
        apply_reset();
        i_enable = 1'b1;
        wait_rd_high("to_start", 2);
        send_words(40);
        n = 0;
        while (o_fifo_rd === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        checks++; if (n != 256) begin errors++; $display("FAIL to_drop: rd dropped after %0d cycles want 256", n); end
        checks++; if (o_pb_level !== 9'd40) begin errors++; $display("FAIL to_level: got %0d want 40", o_pb_level); end
        checks++; if (o_dbg_state !== ST_GAP) begin errors++; $display("FAIL to_gap: got %b want %b", o_dbg_state, ST_GAP); end
        wait_rd_high("to_rerequest", 10);
        i_fifo_rd_done = 1'b1;
        tick();
        i_fifo_rd_done = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_underrun();
        apply_reset();
        i_enable = 1'b1;
        send_words(3);
        for (int i = 0; i < 3; i++) begin
            i_pb_req = 1'b1;
            tick();
            checks++;
            if (o_pb_valid !== 1'b1 || o_pb_data !== exp_data) begin
                errors++; $display("FAIL ur_pop[%0d]: got valid=%b data=%h want valid=1 data=%h", i, o_pb_valid, o_pb_data, exp_data);
            end
        end
        tick();
        checks++; if (o_underrun !== 1'b1) begin errors++; $display("FAIL ur_flag: got %b want 1", o_underrun); end
        checks++; if (o_pb_data !== 16'h0) begin errors++; $display("FAIL ur_silence: got %h want 0", o_pb_data); end
        checks++; if (o_pb_valid !== 1'b0) begin errors++; $display("FAIL ur_valid: got %b want 0", o_pb_valid); end
        i_pb_req = 1'b0;
        repeat (3) tick();
        checks++; if (o_underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b want 1", o_underrun); end
        send_words(10);
        checks++; if (o_pb_level !== 9'd10) begin errors++; $display("FAIL ur_level10: got %0d want 10", o_pb_level); end
        i_fifo_rd_ef   = 1'b1;
        i_fifo_rd_data = 16'($urandom_range(1, 65535));
        i_pb_req       = 1'b1;
        tick();
        idle_inputs();
        checks++; if (o_pb_level !== 9'd10) begin errors++; $display("FAIL ur_simul_level: got %0d want 10", o_pb_level); end
        checks++;
        if (o_pb_valid !== 1'b1 || o_pb_data !== exp_data) begin
            errors++; $display("FAIL ur_simul_pop: got valid=%b data=%h want valid=1 data=%h", o_pb_valid, o_pb_data, exp_data);
        end
        i_fifo_rd_done = 1'b1;
        tick();
        i_fifo_rd_done = 1'b0;
    endtask

    task automatic test_disable();
        int n;
        apply_reset();
        i_enable = 1'b1;
        wait_rd_high("dis_start", 2);
        send_words(20);
        i_enable    = 1'b0;
        i_cap_valid = 1'b1;
        i_cap_data  = 16'h1234;
        #1;
        checks++; if (o_fifo_wr !== 1'b0) begin errors++; $display("FAIL dis_cap_wr: got %b want 0", o_fifo_wr); end
        tick();
        checks++; if (o_fifo_rd !== 1'b0) begin errors++; $display("FAIL dis_rd: got %b want 0", o_fifo_rd); end
        checks++; if (o_dbg_state !== ST_GAP) begin errors++; $display("FAIL dis_gap: got %b want %b", o_dbg_state, ST_GAP); end
        send_words(2);
        checks++; if (o_pb_level !== 9'(exp_q.size()) || exp_q.size() != 22) begin
            errors++; $display("FAIL dis_late_words: got %0d want 22", o_pb_level);
        end
        n = 0;
        while (o_pb_level !== 9'd0 && n < 10) begin
            tick();
            n++;
        end
        checks++; if (o_pb_level !== 9'd0) begin errors++; $display("FAIL dis_flush: got %0d want 0", o_pb_level); end
        exp_q.delete();
        repeat (3) tick();
        checks++; if (o_dbg_state !== ST_IDLE || o_fifo_rd !== 1'b0) begin
            errors++; $display("FAIL dis_stay_idle: got state=%b rd=%b want %b/0", o_dbg_state, o_fifo_rd, ST_IDLE);
        end
        idle_inputs();
        // asynchronous reset while a wave is being read
        i_enable = 1'b1;
        wait_rd_high("arst_start", 3);
        send_words(5);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (o_fifo_rd !== 1'b0) begin errors++; $display("FAIL arst_rd: got %b want 0", o_fifo_rd); end
        checks++; if (o_dbg_state !== ST_IDLE) begin errors++; $display("FAIL arst_state: got %b want %b", o_dbg_state, ST_IDLE); end
        checks++; if (o_pb_level !== 9'd0) begin errors++; $display("FAIL arst_level: got %0d want 0", o_pb_level); end
        checks++; if (o_pb_valid !== 1'b0 || o_underrun !== 1'b0 || o_cap_drop !== 1'b0) begin
            errors++; $display("FAIL arst_flags: got valid=%b underrun=%b drop=%b want 0/0/0", o_pb_valid, o_underrun, o_cap_drop);
        end
        apply_reset();
    endtask

    task automatic test_back_to_back();
        bit prev_drop;
        apply_reset();
        i_enable  = 1'b1;
        prev_drop = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            i_fifo_rd_ef   = ($urandom_range(0, 2) == 0);
            i_fifo_rd_data = 16'($urandom);
            i_fifo_rd_done = ($urandom_range(0, 49) == 0);
            i_pb_req       = ($urandom_range(0, 2) == 0);
            i_cap_valid    = $urandom_range(0, 1);
            i_cap_data     = 16'($urandom);
            i_fifo_full    = ($urandom_range(0, 3) == 0);
            #1;
            checks++;
            if (o_fifo_wr !== (i_cap_valid & !i_fifo_full)) begin
                errors++; $display("FAIL b2b_wr[%0d]: got %b want %b", i, o_fifo_wr, i_cap_valid & !i_fifo_full);
            end
            prev_drop = i_cap_valid & i_fifo_full;
            tick();
            checks++;
            if (o_pb_level !== 9'(exp_q.size())) begin errors++; $display("FAIL b2b_level[%0d]: got %0d want %0d", i, o_pb_level, exp_q.size()); end
            checks++;
            if (o_pb_valid !== exp_valid || o_pb_data !== exp_data) begin
                errors++; $display("FAIL b2b_pb[%0d]: got valid=%b data=%h want valid=%b data=%h", i, o_pb_valid, o_pb_data, exp_valid, exp_data);
            end
            checks++;
            if (o_underrun !== exp_underrun || o_cap_drop !== prev_drop) begin
                errors++; $display("FAIL b2b_flags[%0d]: got underrun=%b drop=%b want %b/%b", i, o_underrun, o_cap_drop, exp_underrun, prev_drop);
            end
        end
        idle_inputs();
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_refill();
        test_cap_drop();
        test_threshold();
        test_timeout();
        test_underrun();
        test_disable();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
